mem_to_array_reader: RTL
========================

# mem_to_array_reader

Reads 8x8 blocks of 32-bit coefficients back out of the 2048-word block memory and presents each as a 2-D array. It is the read-side counterpart of the block-to-memory writer. Word `blk*64 + j*8 + k` maps to `output_data_array[j][k]`. It sits between the block memory (synchronous read port) and the next coefficient-processing stage, with a valid/ready handshake on the output.

## Interface
Parameters:
- `DATA_W`, 32, coefficient word width
- `MEM_DEPTH`, 2048, memory words; must be a multiple of 64
- `ADDR_W`, 11, log2(`MEM_DEPTH`)
- `BLK_W`, 6, block index/count width (`MEM_DEPTH`/64 = 32 blocks, plus count 32)

Ports:
- `clock`  in  1  sole clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_block`  in  `BLK_W`  first block index; bits [4:0] used; captured on `start`
- `block_count`  in  `BLK_W`  number of blocks, 0..32; captured on `start`
- `mem_rd_en`  out  1  memory read strobe
- `mem_addr`  out  `ADDR_W`  memory word address
- `mem_rd_data`  in  `DATA_W`  read data, valid one cycle after the address is sampled
- `output_data_array`  out  `DATA_W` x [8][8]  assembled block
- `out_valid`  out  1  block available
- `out_ready`  in  1  consumer accepts block
- `busy`  out  1  high whenever not IDLE
- `done`  out  1  one-cycle pulse after the last block is accepted

## Operation
- FSM states: IDLE, READ, DRAIN, HOLD, FINISH.
- IDLE + `start`:
  - `block_count`=0 → FINISH.
  - Otherwise → READ, with blk = `base_block`[4:0], remaining = `block_count`, word index w = 0.
- READ: drive `mem_rd_en`=1, `mem_addr` = {blk, w[5:0]}. w increments each cycle. After w=63 → DRAIN.
- Capture: a registered read-valid flag and a delayed index follow each read. Returning data is written to `output_data_array`[idx[5:3]][idx[2:0]] one cycle after the memory samples the address.
- DRAIN: wait until word 63 is captured, then → HOLD with `out_valid`=1.
- HOLD: `output_data_array` and `out_valid` are stable until `out_valid && out_ready`. On the handshake edge:
  - remaining decrements.
  - If the new remaining is nonzero: blk = (blk+1) mod 32 (wraps 31→0), → READ.
  - Otherwise → FINISH.
- FINISH: `done`=1 for one cycle → IDLE.
- `start` outside IDLE is ignored. `base_block`/`block_count` changes after capture have no effect.
- `output_data_array` keeps its last block after completion. It is overwritten word-by-word during the next READ/DRAIN, so consumers use it only while `out_valid`.
- Reset (asynchronous, any state, including mid-READ or mid-HOLD):
  - State → IDLE.
  - All outputs 0: `mem_rd_en`, `mem_addr`, `out_valid`, `busy`, `done`, every `output_data_array` element.
  - Internal counters 0; pending read-returns discarded.

## Timing
- Edge E0 samples `start`. Address k (k=0..63) is driven after E_k. The memory samples it at E_{k+1}; the reader captures at E_{k+2}.
- Word 63 is captured at E65. `out_valid` is registered high at E65 (first visible cycle after E65).
- With `out_ready` held high:
  - Handshake at E66.
  - Next block's first address is driven after E66.
  - Per-block period: 66 cycles.
- `done` is high the cycle after the final handshake edge. `busy` falls with the same edge that drops `done`.
- `block_count`=0: `done` is high the cycle after E0; no `mem_rd_en` ever asserted.
- `out_ready` high while `out_valid` is low has no effect. Consumer backpressure stalls only in HOLD; no reads are issued in HOLD.

## Structure
- Shared package `prores_mem_pkg`:
  - `BLOCK_DIM`=8 and `BLOCK_WORDS`=64.
  - `MEM_DEPTH` default.
  - Reader FSM state enum `rd_state_t`.
  - Word-to-(row,col) index helper, shared with the writer so both sides use one mapping.
- One sub-module, `block_addr_gen`: holds blk/w/remaining counters, produces `mem_addr`/`mem_rd_en`, and the block-wrap and last-word flags. The FSM, capture pipeline and output array live in the top module.

## Test plan
- Memory preloaded with word a = a; `start`, base 0, count 1, `out_ready`=1 → `out_valid` first seen after E65; `output_data_array[j][k]` = j*8+k; `done` pulses one cycle after the handshake edge.
- Base 31, count 2 → addresses 1984..2047 then 0..63 (wrap); blocks delivered in order with data = address.
- Count 3, `out_ready` low 20 cycles on block 1 → array and `out_valid` stable throughout; `mem_rd_en` stays 0 while in HOLD; all 3 blocks correct; exactly one `done`.
- Count 0 → no `mem_rd_en`; `done` one cycle after `start`; `start` pulsed while `busy` during a count-2 run → ignored, still exactly 2 blocks.
- `reset_n` low at E30 of block 0 → all outputs 0 immediately; after release, fresh `start` with base 5, count 1 → block 5 delivered correctly with no stale words.

Source files
------------

// File: rtl/prores_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prores_mem_pkg
// Purpose : Shared definitions for the coefficient block memory readers and
//           writers: block geometry, default memory depth, reader FSM state
//           encoding and the single word-to-(row,col) mapping both sides use.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package prores_mem_pkg;

    localparam int BLOCK_DIM         = 8;
    localparam int BLOCK_WORDS       = BLOCK_DIM * BLOCK_DIM;
    localparam int MEM_DEPTH_DEFAULT = 2048;

    typedef enum logic [2:0] {
        RD_IDLE   = 3'd0,
        RD_READ   = 3'd1,
        RD_DRAIN  = 3'd2,
        RD_HOLD   = 3'd3,
        RD_FINISH = 3'd4
    } rd_state_t;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } blk_pos_t;

    // Word j*8+k inside a block lives at row j, column k.
    function automatic blk_pos_t word_to_pos(input logic [5:0] idx);
        blk_pos_t pos;
        pos.row = idx[5:3];
        pos.col = idx[2:0];
        return pos;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_to_array_reader_block_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : block_addr_gen
// Purpose : Block/word/remaining counters for the block reader. Drives the
//           memory read strobe and address {blk, w} and flags the last word
//           of a block and the last block of a run.
// Ports   : clock, reset_n        - clock, async active-low reset
//           load                  - start a run from base_block/block_count
//           step                  - advance one word while reading
//           accept                - current block handed off downstream
//           base_block, block_count - run parameters (captured on load)
//           mem_rd_en, mem_addr   - memory read port
//           last_word, last_block - status flags to the controlling FSM
// Rev     : 1.0  initial release
// ============================================================================
module block_addr_gen
    import prores_mem_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int BLK_W  = 6
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      load,
    input  logic                                      step,
    input  logic                                      accept,
    input  logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0]     base_block,
    input  logic [BLK_W-1:0]                          block_count,
    output logic                                      mem_rd_en,
    output logic [ADDR_W-1:0]                         mem_addr,
    output logic                                      last_word,
    output logic                                      last_block
);

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = ADDR_W - WORD_W;

    logic [IDX_W-1:0]  r_blk;
    logic [WORD_W-1:0] r_w;
    logic [BLK_W-1:0]  r_remaining;
    logic              r_rd_en;
    logic              w_blk_wrap;

    assign w_blk_wrap = (r_blk == {IDX_W{1'b1}});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blk       <= '0;
            r_w         <= '0;
            r_remaining <= '0;
            r_rd_en     <= 1'b0;
        end else if (load) begin
            r_blk       <= base_block;
            r_w         <= '0;
            r_remaining <= block_count;
            r_rd_en     <= 1'b1;
        end else if (accept) begin
            r_remaining <= r_remaining - BLK_W'(1);
            // Another block follows: restart the word counter on the next
            // block index, wrapping from the top of memory back to block 0.
            if (!last_block) begin
                r_blk   <= w_blk_wrap ? '0 : r_blk + IDX_W'(1);
                r_w     <= '0;
                r_rd_en <= 1'b1;
            end
        end else if (step) begin
            if (r_w == WORD_W'(BLOCK_WORDS - 1)) begin
                r_rd_en <= 1'b0;
            end else begin
                r_w <= r_w + WORD_W'(1);
            end
        end
    end

    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = {r_blk, r_w};
    assign last_word  = r_rd_en && (r_w == WORD_W'(BLOCK_WORDS - 1));
    assign last_block = (r_remaining == BLK_W'(1));

endmodule
`default_nettype wire

// File: rtl/mem_to_array_reader.sv
`default_nettype none
// ============================================================================
// Module  : mem_to_array_reader
// Purpose : Reads 8x8 blocks of coefficients out of the block memory and
//           presents each one as a 2-D array with a valid/ready handshake.
//           Word blk*64 + j*8 + k lands in output_data_array[j][k].
// Ports   : clock, reset_n      - clock, async active-low reset
//           start               - run request (sampled in IDLE only)
//           base_block          - first block index (low 5 bits used)
//           block_count         - blocks to read, 0..32
//           mem_rd_en, mem_addr - synchronous memory read request
//           mem_rd_data         - read data, one cycle after address sample
//           output_data_array   - assembled block
//           out_valid/out_ready - block handshake
//           busy                - high whenever not IDLE
//           done                - one-cycle pulse at end of run
// Rev     : 1.0  initial release
// ============================================================================
module mem_to_array_reader
    import prores_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int ADDR_W    = $clog2(MEM_DEPTH),
    parameter int BLK_W     = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [BLK_W-1:0]    base_block,
    input  logic [BLK_W-1:0]    block_count,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic [DATA_W-1:0]   output_data_array [BLOCK_DIM][BLOCK_DIM],
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam int WORD_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W  = ADDR_W - WORD_W;

    rd_state_t         r_state;
    rd_state_t         w_next_state;
    logic              w_load;
    logic              w_step;
    logic              w_accept;
    logic              w_last_word;
    logic              w_last_block;
    logic              w_drain_done;
    logic              r_rd_valid;
    logic [WORD_W-1:0] r_idx;
    blk_pos_t          w_pos;
    logic              w_unused_base;

    // Block indices above the memory size are not addressable.
    assign w_unused_base = ^base_block[BLK_W-1:IDX_W];

    block_addr_gen #(
        .ADDR_W (ADDR_W),
        .BLK_W  (BLK_W)
    ) u_addr_gen (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (w_load),
        .step        (w_step),
        .accept      (w_accept),
        .base_block  (base_block[IDX_W-1:0]),
        .block_count (block_count),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .last_word   (w_last_word),
        .last_block  (w_last_block)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (start) begin
                    if (block_count == '0) begin
                        w_next_state = RD_FINISH;
                    end else begin
                        w_load       = 1'b1;
                        w_next_state = RD_READ;
                    end
                end
            end
            RD_READ: begin
                w_step = 1'b1;
                if (w_last_word) begin
                    w_next_state = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (w_drain_done) begin
                    w_next_state = RD_HOLD;
                end
            end
            RD_HOLD: begin
                if (out_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = w_last_block ? RD_FINISH : RD_READ;
                end
            end
            RD_FINISH: begin
                w_next_state = RD_IDLE;
            end
            default: begin
                w_next_state = RD_IDLE;
            end
        endcase
    end

    assign out_valid = (r_state == RD_HOLD);
    assign busy      = (r_state != RD_IDLE);
    assign done      = (r_state == RD_FINISH);

    // ------------------------------------------------------------------
    // Capture pipeline: the memory samples the address one edge after it
    // is driven, so the strobe and word index are delayed by one edge to
    // line up with the returning data.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_rd_valid <= mem_rd_en;
            r_idx      <= mem_addr[WORD_W-1:0];
        end
    end

    // The last word of the block is written on the same edge that moves
    // the FSM into HOLD, so the array is complete as out_valid rises.
    assign w_drain_done = r_rd_valid && (r_idx == WORD_W'(BLOCK_WORDS - 1));
    assign w_pos        = word_to_pos(r_idx);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < BLOCK_DIM; j++) begin
                for (int k = 0; k < BLOCK_DIM; k++) begin
                    output_data_array[j][k] <= '0;
                end
            end
        end else if (r_rd_valid) begin
            output_data_array[w_pos.row][w_pos.col] <= mem_rd_data;
        end
    end

endmodule
`default_nettype wire
